// File: rtl/mmio_switch_debouncer.sv
// Memory-mapped slide-switch input: synchronizer, per-bit debounce, sticky change register.
// Optional SW_IRQ_EN adds a writable irq mask at BASE_ADDR+3 and a registered change interrupt.
module mmio_switch_debouncer #(
    parameter int          WIDTH          = 16,
    parameter logic [31:0] BASE_ADDR      = 32'd4000,
    parameter int          TICK_DIV       = 100000,
    parameter int          STABLE_SAMPLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  sw_in,
    input  logic [31:0]       io_addr,
    input  logic              io_rd,
`ifdef SW_IRQ_EN
    input  logic              io_wr,
    input  logic [31:0]       io_wdata,
`endif
    output logic [31:0]       rd_data,
    output logic              hit,
    output logic              irq
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
    logic [WIDTH-1:0] sw_changed_next;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] mask_rd;

    logic [WIDTH-1:0][STABLE_SAMPLES-1:0] window;
    logic [WIDTH-1:0][STABLE_SAMPLES-1:0] window_next;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          sel_val;
    logic          sel_chg;
    logic          sel_msk;
    logic          clr;

    assign tick    = (tick_cnt == TICK_LAST);
    assign sel_val = (io_addr == BASE_ADDR);
    assign sel_chg = (io_addr == BASE_ADDR + 32'd2);
    assign clr     = io_rd & sel_chg;
    assign hit     = sel_val | sel_chg | sel_msk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sw_sync <= '0;
        end else begin
            sync1   <= sw_in;
            sw_sync <= sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Acceptance looks at the window including the sample taken this tick.
    always_comb begin
        window_next = '0;
        toggle      = '0;
        for (int b = 0; b < WIDTH; b++) begin
            window_next[b] = {window[b][STABLE_SAMPLES-2:0], sw_sync[b]};
            if (sw_stable[b]) begin
                toggle[b] = tick & ~(|window_next[b]);
            end else begin
                toggle[b] = tick & (&window_next[b]);
            end
        end
    end

    // A new change bit beats a same-cycle clear.
    assign sw_changed_next = (clr ? '0 : sw_changed) | toggle;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window     <= '0;
            sw_stable  <= '0;
            sw_changed <= '0;
        end else begin
            if (tick) begin
                window <= window_next;
            end
            sw_stable  <= sw_stable ^ toggle;
            sw_changed <= sw_changed_next;
        end
    end

`ifdef SW_IRQ_EN
    logic [WIDTH-1:0] irq_mask;
    logic             irq_q;

    assign sel_msk = (io_addr == BASE_ADDR + 32'd3);
    assign mask_rd = irq_mask;
    assign irq     = irq_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (io_wr && sel_msk) begin
                irq_mask <= io_wdata[WIDTH-1:0];
            end
            irq_q <= |(sw_changed_next & irq_mask);
        end
    end

    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^io_wdata[31:WIDTH];
    end
`else
    assign sel_msk = 1'b0;
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (sel_val) begin
            rd_data = 32'(sw_stable);
        end else if (sel_chg) begin
            rd_data = 32'(sw_changed);
        end else if (sel_msk) begin
            rd_data = 32'(mask_rd);
        end
    end

endmodule

// File: tb/tb_mmio_switch_debouncer.sv
// Directed bench for mmio_switch_debouncer with TICK_DIV=4, STABLE_SAMPLES=3.
// Define SW_IRQ_EN to also exercise the irq mask path.
module tb_mmio_switch_debouncer;

    logic        clock;
    logic        reset;
    logic [15:0] sw_in;
    logic [31:0] io_addr;
    logic        io_rd;
    logic [31:0] rd_data;
    logic        hit;
    logic        irq;
`ifdef SW_IRQ_EN
    logic        io_wr;
    logic [31:0] io_wdata;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    mmio_switch_debouncer #(
        .WIDTH(16),
        .BASE_ADDR(32'd4000),
        .TICK_DIV(4),
        .STABLE_SAMPLES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw_in(sw_in),
        .io_addr(io_addr),
        .io_rd(io_rd),
`ifdef SW_IRQ_EN
        .io_wr(io_wr),
        .io_wdata(io_wdata),
`endif
        .rd_data(rd_data),
        .hit(hit),
        .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        io_addr = a;
        #1;
    endtask

    // Advance until any masked bit of the addressed register is set; n=-1 on timeout.
    task automatic wait_rd(input logic [31:0] a, input logic [31:0] m,
                           input int max, output int cnt);
        io_addr = a;
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if ((rd_data & m) != 32'd0) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        sw_in   = 16'h0000;
        io_addr = 32'd0;
        io_rd   = 1'b0;
`ifdef SW_IRQ_EN
        io_wr    = 1'b0;
        io_wdata = 32'd0;
`endif
        repeat (3) step();

        rd(32'd4000);
        check("rst_val", rd_data, 32'h0);
        check("rst_hit", {31'd0, hit}, 32'd1);
        rd(32'd4002);
        check("rst_chg", rd_data, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // 1: clean rise on bit 0, accepted at edge 2 + 3 ticks (12 edges)
        reset = 1'b0;
        sw_in = 16'h0001;
        wait_rd(32'd4000, 32'hFFFF_FFFF, 15, n);
        check("t1_in_time", {31'd0, n > 0 && n <= 15}, 32'd1);
        check("t1_val", rd_data, 32'h0000_0001);
        rd(32'd4002);
        check("t1_chg", rd_data, 32'h0000_0001);

        rd(32'd4001);
        check("dec_4001", rd_data, 32'h0);
        check("dec_4001_hit", {31'd0, hit}, 32'd0);
        rd(32'd3999);
        check("dec_3999", rd_data, 32'h0);
        rd(32'd4003);
        check("dec_4003", rd_data, 32'h0);
`ifdef SW_IRQ_EN
        check("dec_4003_hit", {31'd0, hit}, 32'd1);
`else
        check("dec_4003_hit", {31'd0, hit}, 32'd0);
`endif

        // 2: clear-on-read returns the pre-clear value
        step();
        io_rd = 1'b1;
        rd(32'd4002);
        check("t2_rd_pre", rd_data, 32'h0000_0001);
        step();
        io_rd = 1'b0;
        rd(32'd4002);
        check("t2_rd_post", rd_data, 32'h0);
        sw_in = 16'h0000;
        wait_rd(32'd4002, 32'hFFFF_FFFF, 20, n);
        check("t2_fall_seen", {31'd0, n > 0}, 32'd1);
        io_rd = 1'b1;
        rd(32'd4000);
        step();
        step();
        io_rd = 1'b0;
        rd(32'd4002);
        check("t2_val_rd_keeps", rd_data, 32'h0000_0001);
        rd(32'd4000);
        check("t2_val_fell", rd_data, 32'h0);
        step();
        io_rd = 1'b1;
        rd(32'd4002);
        step();
        io_rd = 1'b0;

        // 3: 6-cycle glitch cannot fill a 3-sample window
        sw_in = 16'h0008;
        repeat (6) step();
        sw_in = 16'h0000;
        repeat (20) step();
        rd(32'd4000);
        check("t3_val", rd_data, 32'h0);
        rd(32'd4002);
        check("t3_chg", rd_data, 32'h0);

        // 4: clear held active across the toggle edge; set must win
        sw_in = 16'h8001;
        io_rd = 1'b1;
        wait_rd(32'd4002, 32'hFFFF_FFFF, 20, n);
        io_rd = 1'b0;
        check("t4_seen", {31'd0, n > 0}, 32'd1);
        check("t4_chg_edge", rd_data, 32'h0000_8001);
        step();
        rd(32'd4002);
        check("t4_chg_kept", rd_data, 32'h0000_8001);
        rd(32'd4000);
        check("t4_val", rd_data, 32'h0000_8001);
        step();
        io_rd = 1'b1;
        rd(32'd4002);
        step();
        io_rd = 1'b0;

        // 5: reset mid-debounce, then fresh acceptance from a clean counter
        sw_in = 16'h00F0;
        repeat (4) step();
        reset = 1'b1;
        rd(32'd4000);
        check("t5_rst_val", rd_data, 32'h0);
        rd(32'd4002);
        check("t5_rst_chg", rd_data, 32'h0);
        step();
        reset = 1'b0;
        wait_rd(32'd4000, 32'hFFFF_FFFF, 20, n);
        check("t5_latency", {31'd0, n >= 12 && n <= 15}, 32'd1);
        check("t5_val", rd_data, 32'h0000_00F0);
        rd(32'd4002);
        check("t5_chg", rd_data, 32'h0000_00F0);
        check("t5_irq", {31'd0, irq}, 32'd0);

`ifdef SW_IRQ_EN
        // 6: masked change interrupt
        sw_in = 16'h0000;
        reset = 1'b1;
        step();
        reset    = 1'b0;
        io_wr    = 1'b1;
        io_wdata = 32'h0000_0002;
        io_addr  = 32'd4003;
        step();
        io_wr = 1'b0;
        rd(32'd4003);
        check("t6_mask", rd_data, 32'h0000_0002);
        sw_in = 16'h0001;
        wait_rd(32'd4002, 32'h0000_0001, 20, n);
        check("t6_b0_seen", {31'd0, n > 0}, 32'd1);
        step();
        check("t6_b0_noirq", {31'd0, irq}, 32'd0);
        sw_in = 16'h0003;
        wait_rd(32'd4002, 32'h0000_0002, 20, n);
        check("t6_b1_seen", {31'd0, n > 0}, 32'd1);
        check("t6_irq", {31'd0, irq}, 32'd1);
        io_rd = 1'b1;
        step();
        io_rd = 1'b0;
        check("t6_irq_clr", {31'd0, irq}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
